// File: rtl/mod_chain_counter.sv
// -----------------------------------------------------------------------------
// mod_chain_counter
//
// Cascade of NUM_STAGES modulo counters, stage 0 least significant. Each stage
// wraps at its own modulus and carries (up) or borrows (down) into the next
// stage. The whole ripple resolves in a single cycle. Also supports a
// synchronous saturating load and a single-stage adjust that steps one stage
// without carry or borrow (used when setting the clock).
//
// Default configuration is the digital-clock time base: 3 stages, moduli
// 24:60:60 (stage2:stage1:stage0 = hh:mm:ss), en driven by the 1 Hz tick.
//
// Parameters
//   NUM_STAGES  number of cascaded stages (1..8)
//   W           bits per stage count field
//   MODS        stage k modulus = MODS[32k+:32]; 2 <= MOD <= 2^W
//   SELW        width of adj_sel; 2^SELW >= NUM_STAGES
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   en          in   count tick, one step per cycle while high
//   up_down     in   1 = count up, 0 = count down
//   load        in   synchronous load strobe
//   load_data   in   load value, stage k at [W*k+:W]
//   adj_stb     in   single-stage adjust strobe
//   adj_sel     in   stage index to adjust
//   adj_dir     in   1 = +1, 0 = -1 on the adjusted stage
//   count       out  registered stage values, stage k at [W*k+:W]
//   stage_tick  out  registered, bit k high one cycle when stage k stepped
//   wrap        out  registered, high one cycle when the whole chain wrapped
//
// Priority each cycle: reset > load > adj_stb > en; at most one action.
// -----------------------------------------------------------------------------
module mod_chain_counter #(
    parameter int unsigned                    NUM_STAGES = 3,
    parameter int unsigned                    W          = 6,
    parameter logic [NUM_STAGES*32-1:0]       MODS       = {32'd24, 32'd60, 32'd60},
    parameter int unsigned                    SELW       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [NUM_STAGES*W-1:0] load_data,
    input  logic                    adj_stb,
    input  logic [SELW-1:0]         adj_sel,
    input  logic                    adj_dir,
    output logic [NUM_STAGES*W-1:0] count,
    output logic [NUM_STAGES-1:0]   stage_tick,
    output logic                    wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if ((64'd1 << SELW) < 64'(NUM_STAGES)) begin : g_bad_selw
            $error("mod_chain_counter: 2^SELW (%0d) < NUM_STAGES (%0d)",
                   (1 << SELW), NUM_STAGES);
        end
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_chk
            if (MODS[32*g +: 32] < 32'd2) begin : g_bad_min
                $error("mod_chain_counter: stage %0d modulus %0d < 2",
                       g, MODS[32*g +: 32]);
            end
            if ({32'd0, MODS[32*g +: 32]} > (64'd1 << W)) begin : g_bad_max
                $error("mod_chain_counter: stage %0d modulus %0d > 2^W",
                       g, MODS[32*g +: 32]);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_STAGES*W-1:0] r_count;
    logic [NUM_STAGES-1:0]   r_stage_tick;
    logic                    r_wrap;
    // Low from reset until one clock after its release: actions start on the
    // second edge after release, so a reset that drops close to an edge never
    // produces a partial first update.
    logic                    r_run;

    // -------------------------------------------------------------------------
    // Per-stage views
    // -------------------------------------------------------------------------
    logic [W-1:0]            w_max  [NUM_STAGES];
    logic [W-1:0]            w_cur  [NUM_STAGES];
    logic [NUM_STAGES-1:0]   w_term;

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
            assign w_max[g]  = W'(MODS[32*g +: 32] - 32'd1);
            assign w_cur[g]  = r_count[W*g +: W];
            // Terminal value depends on the counting direction of this cycle.
            assign w_term[g] = up_down ? (w_cur[g] == w_max[g]) : (w_cur[g] == '0);
        end
    endgenerate

    // One modulo step of a single stage in the given direction.
    function automatic logic [W-1:0] f_step(input logic [W-1:0] cur,
                                            input logic [W-1:0] max,
                                            input logic         dir);
        if (dir) begin
            return (cur == max) ? '0 : cur + ONE;
        end else begin
            return (cur == '0) ? max : cur - ONE;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [NUM_STAGES*W-1:0] w_count_nxt;
    logic [NUM_STAGES-1:0]   w_tick_nxt;
    logic                    w_wrap_nxt;
    logic                    w_carry;

    always_comb begin
        w_count_nxt = r_count;
        w_tick_nxt  = '0;
        w_wrap_nxt  = 1'b0;
        w_carry     = 1'b0;

        if (r_run) begin
            if (load) begin
                // Out-of-range fields saturate to MOD-1 so every stage stays valid.
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    w_count_nxt[W*k +: W] = (load_data[W*k +: W] > w_max[k]) ?
                                            w_max[k] : load_data[W*k +: W];
                end
            end else if (adj_stb) begin
                // An out-of-range adj_sel matches no stage: nothing changes.
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (SELW'(k) == adj_sel) begin
                        w_count_nxt[W*k +: W] = f_step(w_cur[k], w_max[k], adj_dir);
                        w_tick_nxt[k]         = 1'b1;
                    end
                end
            end else if (en) begin
                // Carry ripples combinationally; w_carry after the last stage
                // is step(top) && top terminal, i.e. the chain wrap.
                w_carry = 1'b1;
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (w_carry) begin
                        w_count_nxt[W*k +: W] = f_step(w_cur[k], w_max[k], up_down);
                        w_tick_nxt[k]         = 1'b1;
                    end
                    w_carry = w_carry & w_term[k];
                end
                w_wrap_nxt = w_carry;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_count      <= '0;
            r_stage_tick <= '0;
            r_wrap       <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_count      <= w_count_nxt;
            r_stage_tick <= w_tick_nxt;
            r_wrap       <= w_wrap_nxt;
        end
    end

    assign count      = r_count;
    assign stage_tick = r_stage_tick;
    assign wrap       = r_wrap;

endmodule
